// File: rtl/logic_capture_fifo.sv
// logic_capture_fifo: timestamped per-pin edge capture into a show-ahead FIFO drained over valid/ready
module logic_capture_fifo #(
    parameter int WIDTH       = 16,
    parameter int TS_WIDTH    = 16,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         f_pin,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         rise_mask,
    input  logic [WIDTH-1:0]         fall_mask,
    output logic [WIDTH-1:0]         out_data,
    output logic [TS_WIDTH-1:0]      out_ts,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     event_detected,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic [$clog2(DEPTH):0]   fill_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(SYNC_STAGES + 1);
    localparam logic [PW-1:0] PRIME_N = PW'(SYNC_STAGES);
    localparam logic [AW:0]   FULL_N  = (AW+1)'(DEPTH);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]          cur, prev_q;
    logic [PW-1:0]             prime_q, prime_d;
    logic                      primed_q, primed_d;
    logic [TS_WIDTH-1:0]       ts_q;
    logic [AW-1:0]             wr_q, rd_q;
    logic [AW:0]               cnt_q, cnt_d;
    logic                      ev_q, ovf_q, ovf_d;
    logic [TS_WIDTH+WIDTH-1:0] mem [DEPTH];
    logic                      hit, pop, push, drop;

    always_comb begin
        cur      = sync_q[SYNC_STAGES-1];
        hit      = enable & primed_q & |(((~prev_q & cur) & rise_mask) | ((prev_q & ~cur) & fall_mask));
        pop      = (cnt_q != '0) & out_ready;
        push     = hit & ((cnt_q != FULL_N) | pop);
        drop     = hit & ~push;
        prime_d  = (prime_q == PRIME_N) ? prime_q : prime_q + PW'(1);
        // primed one cycle after the counter saturates so prev already holds a real sample
        primed_d = primed_q | (prime_q == PRIME_N);
        cnt_d    = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        ovf_d    = drop | (ovf_q & ~clear_overflow);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            prev_q   <= '0;
            prime_q  <= '0;
            primed_q <= 1'b0;
            ts_q     <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            ev_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], f_pin};
            prev_q   <= cur;
            prime_q  <= prime_d;
            primed_q <= primed_d;
            ts_q     <= ts_q + TS_WIDTH'(1);
            wr_q     <= wr_q + AW'(push);
            rd_q     <= rd_q + AW'(pop);
            cnt_q    <= cnt_d;
            ev_q     <= hit;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= {ts_q, cur};
    end

    assign {out_ts, out_data} = mem[rd_q];
    assign out_valid      = cnt_q != '0;
    assign fill_level     = cnt_q;
    assign event_detected = ev_q;
    assign overflow       = ovf_q;
endmodule
